// File: rtl/spi_master_param.sv
// SPI master with DATA_W-bit words, CLK_DIV clk cycles per SCLK half-period, run-time CPOL/CPHA and NUM_SS chip selects.
// Optional: define SPI_LSB_FIRST_EN to add the lsb_first input (LSB-first transmit and receive).
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 50,
  parameter int NUM_SS  = 1,
  parameter int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic [DATA_W-1:0] rx_data,
  output logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  localparam int HP_W  = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  state_t            state, state_next;
  logic [HP_W-1:0]   hp_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_shift, rx_shift, tx_shifted, rx_captured;
  logic              cpol_q, cpha_q, lsb_q;
  logic [NUM_SS-1:0] ss_dec;
  logic              hp_wrap, leading, bit_last;

`ifdef SPI_LSB_FIRST_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       lsb_q <= 1'b0;
    else if (state == IDLE && start) lsb_q <= lsb_first;
  end
`else
  assign lsb_q = 1'b0;
`endif

  assign hp_wrap  = (hp_cnt == HP_LAST);
  // An edge is leading when SCLK is still at its idle level just before toggling.
  assign leading  = (sclk == cpol_q);
  assign bit_last = (bit_cnt == BIT_LAST);

  assign tx_shifted  = lsb_q ? {1'b0, tx_shift[DATA_W-1:1]} : {tx_shift[DATA_W-2:0], 1'b0};
  assign rx_captured = lsb_q ? {miso, rx_shift[DATA_W-1:1]} : {rx_shift[DATA_W-2:0], miso};

  // Out-of-range ss_sel matches no index, so every select stays high.
  always_comb begin
    for (int i = 0; i < NUM_SS; i++) ss_dec[i] = (int'(ss_sel) != i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;  // NOTE: default assigned first so no path through the case infers a latch.
    unique case (state)
      IDLE:    if (start)   state_next = SETUP;
      SETUP:   if (hp_wrap) state_next = XFER;
      XFER:    if (hp_wrap && !leading && bit_last) state_next = HOLD;
      HOLD:    if (hp_wrap) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_ready = (state == IDLE);
    busy     = (state != IDLE);
    mosi     = 1'b0;
    if (state != IDLE) mosi = lsb_q ? tx_shift[0] : tx_shift[DATA_W-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hp_cnt   <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      sclk     <= 1'b0;
      ss_n     <= '1;
      done     <= 1'b0;
    end else begin
      done   <= 1'b0;  // NOTE: non-blocking throughout so every branch reads pre-edge register values.
      hp_cnt <= (state == IDLE || hp_wrap) ? '0 : hp_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          sclk    <= cpol;
          bit_cnt <= '0;
          if (start) begin
            tx_shift <= tx_data;
            rx_shift <= '0;
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            ss_n     <= ss_dec;
          end
        end
        SETUP: sclk <= cpol_q;
        XFER: begin
          if (hp_wrap) begin
            sclk <= ~sclk;
            if (leading) begin
              if (!cpha_q)              rx_shift <= rx_captured;
              else if (bit_cnt != '0)   tx_shift <= tx_shifted;
            end else begin
              bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
              if (cpha_q)               rx_shift <= rx_captured;
              else if (!bit_last)       tx_shift <= tx_shifted;
            end
          end
        end
        HOLD: begin
          sclk <= cpol_q;
          if (hp_wrap) begin
            ss_n    <= '1;
            rx_data <= rx_shift;
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: DATA_W=8, CLK_DIV=4, four selects, with an SS_W wide enough for out-of-range ss_sel.
// Covers all modes, chip-select decode, back-to-back starts, mid-transfer reset and (with SPI_LSB_FIRST_EN) LSB-first order.
module tb_spi_master_param;

  localparam int DATA_W  = 8;
  localparam int CLK_DIV = 4;
  localparam int NUM_SS  = 4;
  localparam int SS_W    = 3;
  localparam int LAT     = (2 * DATA_W + 2) * CLK_DIV;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              cpol = 1'b0;
  logic              cpha = 1'b0;
  logic [SS_W-1:0]   ss_sel = '0;
  logic [DATA_W-1:0] tx_data = '0;
  logic [DATA_W-1:0] rx_data;
  logic              tx_ready, busy, done, sclk, mosi, miso;
  logic [NUM_SS-1:0] ss_n;
`ifdef SPI_LSB_FIRST_EN
  logic              lsb_first = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] exp_q[$];

  // Slave model: loopback, or a fixed word presented MSB first, advancing after each trailing edge.
  logic              use_slave = 1'b0;
  logic [DATA_W-1:0] slave_word = '0;
  logic              slave_pol = 1'b0;
  logic              slave_prev = 1'b0;
  int                slave_cnt = 0;

  // Per-transfer observations filled by run_xfer.
  int                st_lat, st_low, st_bad_ss, st_rise, st_fall, st_mosi_bad, st_idle_bad, st_mosi_high;
  logic              st_mosi_first;
  logic [DATA_W-1:0] st_tx;

  always #5 clk = ~clk;

  assign miso = use_slave ? ((slave_cnt < DATA_W) ? slave_word[DATA_W-1-slave_cnt] : 1'b0) : mosi;

  always @(negedge clk) begin
    if (ss_n[0])                                   slave_cnt = 0;
    else if (sclk !== slave_prev && sclk === slave_pol) slave_cnt = slave_cnt + 1;
    slave_prev = sclk;
  end

  spi_master_param #(
    .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .NUM_SS(NUM_SS), .SS_W(SS_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cpol(cpol), .cpha(cpha),
    .ss_sel(ss_sel), .tx_data(tx_data),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .rx_data(rx_data), .tx_ready(tx_ready), .busy(busy), .done(done),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  // One full transfer; inputs are scrambled while busy, expected rx goes through the scoreboard.
  task automatic run_xfer(input logic [DATA_W-1:0] data, input logic pol, input logic pha,
                          input logic [SS_W-1:0] sel, input logic [DATA_W-1:0] exp_rx);
    logic [NUM_SS-1:0] mask;
    logic              prev_sclk, prev_mosi, prev_busy;
    logic [DATA_W-1:0] exp_v;
    int                k;
    mask = '1;
    for (int i = 0; i < NUM_SS; i++) if (int'(sel) == i) mask[i] = 1'b0;
    st_lat = -1; st_low = 0; st_bad_ss = 0; st_rise = 0; st_fall = 0;
    st_mosi_bad = 0; st_idle_bad = 0; st_mosi_high = 0; st_mosi_first = 1'b0; st_tx = '0;
    @(negedge clk);
    tx_data = data; cpol = pol; cpha = pha; ss_sel = sel; slave_pol = pol;
    repeat (2) @(negedge clk);
    tests++;
    if (sclk !== pol || tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL idle_before: sclk=%b tx_ready=%b, required sclk=%b tx_ready=1", sclk, tx_ready, pol);
    end
    prev_sclk = sclk; prev_mosi = mosi; prev_busy = busy;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back(exp_rx);
    for (k = 0; k < LAT + 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0; tx_data = ~data; cpol = ~pol; cpha = ~pha; ss_sel = sel ^ 3'b001;
        st_mosi_first = mosi;
      end
      if (ss_n !== '1) st_low++;
      if (ss_n !== '1 && ss_n !== mask) st_bad_ss++;
      if (sclk !== prev_sclk) begin
        if (sclk) st_rise++; else st_fall++;
        if (sclk === (pha ? pol : ~pol)) st_tx = {st_tx[DATA_W-2:0], mosi};
      end
      if (busy && prev_busy && mosi !== prev_mosi &&
          !(sclk !== prev_sclk && sclk === (pha ? ~pol : pol))) st_mosi_bad++;
      if (busy && mosi) st_mosi_high++;
      if ((k < CLK_DIV || k >= LAT - CLK_DIV) && sclk !== pol) st_idle_bad++;
      prev_sclk = sclk; prev_mosi = mosi; prev_busy = busy;
      if (done) begin
        st_lat = k;
        tx_data = data; cpol = pol; cpha = pha; ss_sel = sel;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rx_scoreboard: done with rx_data=%h but nothing expected", rx_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (rx_data !== exp_v) begin
            fails++;
            $display("FAIL rx_scoreboard: rx_data=%h, required %h", rx_data, exp_v);
          end
        end
        break;
      end
    end
    if (st_lat < 0) begin
      tests++; fails++;
      $display("FAIL xfer_timeout: no done within %0d cycles", LAT + 40);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (ss_n !== 4'hF || sclk !== 1'b0 || mosi !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_pins: ss_n=%h sclk=%b mosi=%b done=%b, required F 0 0 0", ss_n, sclk, mosi, done);
    end
    tests++;
    if (rx_data !== 8'h00) begin
      fails++; $display("FAIL reset_rx: rx_data=%h, required 00", rx_data);
    end
    tests++;
    if (busy !== 1'b0 || tx_ready !== 1'b1) begin
      fails++; $display("FAIL reset_status: busy=%b tx_ready=%b, required 0 1", busy, tx_ready);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || tx_ready !== 1'b1 || ss_n !== 4'hF) begin
      fails++; $display("FAIL post_reset_idle: busy=%b tx_ready=%b ss_n=%h, required 0 1 F", busy, tx_ready, ss_n);
    end
  endtask

  task automatic test_mode0;
    use_slave = 1'b0;
    run_xfer(8'hA5, 1'b0, 1'b0, 3'd0, 8'hA5);
    tests++;
    if (st_lat !== LAT) begin fails++; $display("FAIL m0_latency: %0d, required %0d", st_lat, LAT); end
    tests++;
    if (st_low !== LAT || st_bad_ss !== 0) begin
      fails++; $display("FAIL m0_ss: low=%0d bad=%0d, required %0d 0", st_low, st_bad_ss, LAT);
    end
    tests++;
    if (st_rise !== DATA_W || st_fall !== DATA_W) begin
      fails++; $display("FAIL m0_edges: rise=%0d fall=%0d, required %0d each", st_rise, st_fall, DATA_W);
    end
    tests++;
    if (st_tx !== 8'hA5 || st_mosi_bad !== 0) begin
      fails++; $display("FAIL m0_mosi: bits=%h bad=%0d, required A5 0", st_tx, st_mosi_bad);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || rx_data !== 8'hA5) begin
      fails++; $display("FAIL m0_done_pulse: done=%b rx_data=%h, required 0 A5", done, rx_data);
    end
  endtask

  task automatic test_mode3;
    use_slave = 1'b1;
    slave_word = 8'hC3;
    run_xfer(8'h3C, 1'b1, 1'b1, 3'd0, 8'hC3);
    tests++;
    if (st_idle_bad !== 0) begin fails++; $display("FAIL m3_sclk_idle: %0d low cycles in setup/hold, required 0", st_idle_bad); end
    tests++;
    if (st_mosi_bad !== 0 || st_tx !== 8'h3C) begin
      fails++; $display("FAIL m3_mosi: bad=%0d bits=%h, required 0 3C", st_mosi_bad, st_tx);
    end
    tests++;
    if (st_rise !== DATA_W || st_fall !== DATA_W) begin
      fails++; $display("FAIL m3_edges: rise=%0d fall=%0d, required %0d each", st_rise, st_fall, DATA_W);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (sclk !== 1'b1) begin fails++; $display("FAIL m3_sclk_after: sclk=%b, required 1", sclk); end
    use_slave = 1'b0;
  endtask

  task automatic test_num_ss;
    use_slave = 1'b0;
    run_xfer(8'h5A, 1'b0, 1'b0, 3'd2, 8'h5A);
    tests++;
    if (st_low !== LAT || st_bad_ss !== 0) begin
      fails++; $display("FAIL ss_sel2: low=%0d bad=%0d, required %0d 0", st_low, st_bad_ss, LAT);
    end
    run_xfer(8'h33, 1'b0, 1'b1, 3'd5, 8'h33);
    tests++;
    if (st_low !== 0 || st_lat !== LAT) begin
      fails++; $display("FAIL ss_sel5: low=%0d latency=%0d, required 0 %0d", st_low, st_lat, LAT);
    end
  endtask

  task automatic test_back_to_back;
    int k;
    logic [DATA_W-1:0] exp_v;
    use_slave = 1'b0;
    @(negedge clk);
    tx_data = 8'h11; cpol = 1'b0; cpha = 1'b0; ss_sel = 3'd0; start = 1'b1;
    @(posedge clk);
    exp_q.push_back(8'h11);
    @(negedge clk);
    tx_data = 8'h22;
    for (k = 0; k < LAT + 20 && !done; k++) @(negedge clk);
    tests++;
    if (done !== 1'b1 || k != LAT) begin fails++; $display("FAIL b2b_first_done: at %0d, required %0d", k, LAT); end
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
    tests++;
    if (rx_data !== exp_v || tx_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_first_rx: rx_data=%h tx_ready=%b, required %h 1", rx_data, tx_ready, exp_v);
    end
    exp_q.push_back(8'h22);
    @(negedge clk);
    tests++;
    if (tx_ready !== 1'b0 || busy !== 1'b1 || rx_data !== 8'h11) begin
      fails++; $display("FAIL b2b_restart: tx_ready=%b busy=%b rx_data=%h, required 0 1 11", tx_ready, busy, rx_data);
    end
    start = 1'b0;
    for (k = 0; k < LAT + 20 && !done; k++) @(negedge clk);
    tests++;
    if (done !== 1'b1 || k != LAT) begin fails++; $display("FAIL b2b_second_done: at %0d, required %0d", k, LAT); end
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
    tests++;
    if (rx_data !== exp_v) begin fails++; $display("FAIL b2b_second_rx: rx_data=%h, required %h", rx_data, exp_v); end
  endtask

  task automatic test_reset_mid;
    logic saw_done;
    saw_done = 1'b0;
    use_slave = 1'b0;
    @(negedge clk);
    tx_data = 8'h5A; cpol = 1'b1; cpha = 1'b0; ss_sel = 3'd1; start = 1'b1;
    @(posedge clk);
    exp_q.push_back(8'h5A);
    @(negedge clk);
    start = 1'b0;
    repeat (30) begin @(negedge clk); if (done) saw_done = 1'b1; end
    reset = 1'b1;
    #1;
    tests++;
    if (ss_n !== 4'hF || sclk !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pins: ss_n=%h sclk=%b busy=%b tx_ready=%b, required F 0 0 1", ss_n, sclk, busy, tx_ready);
    end
    exp_q.delete();
    repeat (3) begin @(negedge clk); if (done) saw_done = 1'b1; end
    tests++;
    if (saw_done) begin fails++; $display("FAIL reset_mid_done: done=1 seen, required none"); end
    reset = 1'b0;
    run_xfer(8'h96, 1'b0, 1'b0, 3'd0, 8'h96);
    tests++;
    if (st_lat !== LAT || st_low !== LAT || st_tx !== 8'h96) begin
      fails++; $display("FAIL reset_mid_next: latency=%0d low=%0d bits=%h, required %0d %0d 96", st_lat, st_low, st_tx, LAT, LAT);
    end
  endtask

`ifdef SPI_LSB_FIRST_EN
  task automatic test_lsb_first;
    use_slave = 1'b0;
    lsb_first = 1'b1;
    run_xfer(8'h01, 1'b0, 1'b0, 3'd0, 8'h01);
    tests++;
    if (st_mosi_first !== 1'b1 || st_mosi_high !== 3 * CLK_DIV || st_tx !== 8'h80) begin
      fails++;
      $display("FAIL lsb_mosi: first=%b high_cycles=%0d bits=%h, required 1 %0d 80", st_mosi_first, st_mosi_high, st_tx, 3 * CLK_DIV);
    end
    lsb_first = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_mode0;
    test_mode3;
    test_num_ss;
    test_back_to_back;
    test_reset_mid;
`ifdef SPI_LSB_FIRST_EN
    test_lsb_first;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
